// File: rtl/gray_stream_decoder.sv
// Streaming Gray-to-binary decoder with step classification (hold/up/down/jump)
// and a saturating illegal-step counter. Optional parity checking: GRAY_DEC_PARITY_EN.
module gray_stream_decoder #(
  parameter int VEC_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic [VEC_W-1:0]     gray_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
`ifdef GRAY_DEC_PARITY_EN
  input  logic                 gray_par_i,
  output logic                 par_err_o,
`endif
  output logic [VEC_W-1:0]     bin_o,
  output logic [1:0]           dir_o,
  output logic                 step_err_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 state_o
);

  // Handshake: a word moves on a side when its valid and ready are both high in
  // the same cycle. in_ready is combinational on out_ready so a full output
  // register can be replaced in the cycle it drains (one word per cycle).

  typedef enum logic {
    NOREF = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [VEC_W-1:0] ALL_ONES = {VEC_W{1'b1}};
  localparam logic [VEC_W-1:0] ONE      = {{(VEC_W-1){1'b0}}, 1'b1};

  state_t             state_q;
  state_t             state_d;
  logic [VEC_W-1:0]   prev_bin_q;
  logic [VEC_W-1:0]   bin_new;
  logic [VEC_W-1:0]   diff;
  logic [1:0]         dir_new;
  logic               step_err_new;
  logic               par_bad;
  logic               accept;
  logic               load_ref;
  logic               cnt_inc;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign state_o    = state_q;

`ifdef GRAY_DEC_PARITY_EN
  assign par_bad = gray_par_i ^ (^gray_i);
`else
  assign par_bad = 1'b0;
`endif

  // Binary bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    bin_new = '0;
    for (int i = 0; i < VEC_W; i++) begin
      bin_new[i] = ^(gray_i >> i);
    end
  end

  assign diff = bin_new - prev_bin_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= NOREF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a clear forgets the reference, but a same-cycle good word
  // immediately becomes the new one.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = load_ref ? TRACK : NOREF;
    end else if (load_ref) begin
      state_d = TRACK;
    end
  end

  // Output decode: classification of the word being accepted.
  always_comb begin
    dir_new      = 2'b00;
    step_err_new = 1'b0;
    if (state_q == TRACK && !clear_i) begin
      if (diff == '0) begin
        dir_new = 2'b00;
      end else if (diff == ONE) begin
        dir_new = 2'b01;
      end else if (diff == ALL_ONES) begin
        dir_new = 2'b10;
      end else begin
        dir_new      = 2'b11;
        step_err_new = 1'b1;
      end
    end
  end

  assign load_ref = accept && !par_bad;
  assign cnt_inc  = accept && !clear_i && (step_err_new || par_bad);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_bin_q <= '0;
    end else if (load_ref) begin
      prev_bin_q <= bin_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_o <= 1'b0;
      bin_o       <= '0;
      dir_o       <= 2'b00;
      step_err_o  <= 1'b0;
`ifdef GRAY_DEC_PARITY_EN
      par_err_o   <= 1'b0;
`endif
    end else if (accept) begin
      out_valid_o <= 1'b1;
      bin_o       <= bin_new;
      dir_o       <= dir_new;
      step_err_o  <= step_err_new;
`ifdef GRAY_DEC_PARITY_EN
      par_err_o   <= par_bad;
`endif
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // Saturating error counter; a clear wins over any increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_o <= '0;
    end else if (clear_i) begin
      err_cnt_o <= '0;
    end else if (cnt_inc && (err_cnt_o != {ERR_CNT_W{1'b1}})) begin
      err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder: vector table plus hand-written
// backpressure, reset, saturation and (with GRAY_DEC_PARITY_EN) parity sequences.
module tb_gray_stream_decoder;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic [3:0] gray;
  logic       in_valid;
  logic       out_ready;
  logic       in_ready, in_ready2;
  logic [3:0] bin, bin2;
  logic [1:0] dir, dir2;
  logic       step_err, step_err2;
  logic       out_valid, out_valid2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic       state, state2;
`ifdef GRAY_DEC_PARITY_EN
  logic       par_flip;
  logic       gray_par;
  logic       par_err, par_err2;
  assign gray_par = (^gray) ^ par_flip;
`endif

  int checks   = 0;
  int failures = 0;
  logic       sb_en = 1'b0;
  logic [3:0] exp_q[$];

  gray_stream_decoder #(.VEC_W(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .clear_i(clear), .gray_i(gray),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
`ifdef GRAY_DEC_PARITY_EN
    .gray_par_i(gray_par), .par_err_o(par_err),
`endif
    .bin_o(bin), .dir_o(dir), .step_err_o(step_err), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .err_cnt_o(err_cnt), .state_o(state)
  );

  gray_stream_decoder #(.VEC_W(4), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .clear_i(clear), .gray_i(gray),
    .in_valid_i(in_valid), .in_ready_o(in_ready2),
`ifdef GRAY_DEC_PARITY_EN
    .gray_par_i(gray_par), .par_err_o(par_err2),
`endif
    .bin_o(bin2), .dir_o(dir2), .step_err_o(step_err2), .out_valid_o(out_valid2),
    .out_ready_i(out_ready), .err_cnt_o(err_cnt2), .state_o(state2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] g, input logic v, input logic r, input logic c);
    gray      = g;
    in_valid  = v;
    out_ready = r;
    clear     = c;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b1, 1'b0);
    #3;
    tick();
    reset_n = 1'b1;
  endtask

  // Scoreboard: every output transfer must match the next expected word.
  always @(negedge clk) begin
    if (sb_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_beat", {28'd0, bin}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_beat", {28'd0, bin}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic [3:0] gray;
    logic       valid;
    logic       clear;
    logic [3:0] bin;
    logic [1:0] dir;
    logic       err;
    logic       ov;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{4'b0000, 1'b1, 1'b0, 4'd0,  2'b00, 1'b0, 1'b1, 8'd0};
    tbl[1]  = '{4'b0001, 1'b1, 1'b0, 4'd1,  2'b01, 1'b0, 1'b1, 8'd0};
    tbl[2]  = '{4'b0011, 1'b1, 1'b0, 4'd2,  2'b01, 1'b0, 1'b1, 8'd0};
    tbl[3]  = '{4'b0010, 1'b1, 1'b0, 4'd3,  2'b01, 1'b0, 1'b1, 8'd0};
    tbl[4]  = '{4'b0100, 1'b1, 1'b0, 4'd7,  2'b11, 1'b1, 1'b1, 8'd1};
    tbl[5]  = '{4'b1100, 1'b1, 1'b0, 4'd8,  2'b01, 1'b0, 1'b1, 8'd1};
    tbl[6]  = '{4'b1000, 1'b1, 1'b0, 4'd15, 2'b11, 1'b1, 1'b1, 8'd2};
    tbl[7]  = '{4'b0000, 1'b1, 1'b0, 4'd0,  2'b01, 1'b0, 1'b1, 8'd2};
    tbl[8]  = '{4'b1000, 1'b1, 1'b0, 4'd15, 2'b10, 1'b0, 1'b1, 8'd2};
    tbl[9]  = '{4'b1000, 1'b1, 1'b0, 4'd15, 2'b00, 1'b0, 1'b1, 8'd2};
    tbl[10] = '{4'b1101, 1'b1, 1'b1, 4'd9,  2'b00, 1'b0, 1'b1, 8'd0};
    tbl[11] = '{4'b1111, 1'b1, 1'b0, 4'd10, 2'b01, 1'b0, 1'b1, 8'd0};
    tbl[12] = '{4'b0011, 1'b0, 1'b0, 4'd10, 2'b01, 1'b0, 1'b0, 8'd0};

`ifdef GRAY_DEC_PARITY_EN
    par_flip = 1'b0;
`endif
    // Reset state, sampled while reset_n is still low.
    reset_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b1, 1'b0);
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bin", {28'd0, bin}, 32'd0);
    chk("rst_dir", {30'd0, dir}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_state", {31'd0, state}, 32'd0);
    tick();
    reset_n = 1'b1;

    // Table: one word per cycle with out_ready held high.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].gray, tbl[i].valid, 1'b1, tbl[i].clear);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("vec%0d_bin", i), {28'd0, bin}, {28'd0, tbl[i].bin});
      chk($sformatf("vec%0d_dir", i), {30'd0, dir}, {30'd0, tbl[i].dir});
      chk($sformatf("vec%0d_err", i), {31'd0, step_err}, {31'd0, tbl[i].err});
      chk($sformatf("vec%0d_cnt", i), {24'd0, err_cnt}, {24'd0, tbl[i].cnt});
    end

    // Backpressure: reference is bin 10; send 11 then hold 12 for 3 stalled cycles.
    sb_en = 1'b1;
    exp_q.push_back(4'd11);
    drive(4'b1110, 1'b1, 1'b1, 1'b0);
    tick();
    chk("bp_first_dir", {30'd0, dir}, 32'd1);
    exp_q.push_back(4'd12);
    drive(4'b1010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_bin_stable", {28'd0, bin}, 32'd11);
      chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
    end
    drive(4'b1010, 1'b1, 1'b1, 1'b0);
    tick();
    chk("bp_release_bin", {28'd0, bin}, 32'd12);
    chk("bp_release_dir", {30'd0, dir}, 32'd1);
    drive(4'b1010, 1'b0, 1'b1, 1'b0);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_queue_empty", exp_q.size(), 32'd0);
    sb_en = 1'b0;

    // Reset mid-stream with a pending beat.
    drive(4'b0001, 1'b1, 1'b1, 1'b0);
    tick();
    chk("mid_jump_dir", {30'd0, dir}, 32'd3);
    chk("mid_jump_cnt", {24'd0, err_cnt}, 32'd1);
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mid_pending", {31'd0, out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_cnt", {24'd0, err_cnt}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    reset_n = 1'b1;
    drive(4'b0110, 1'b1, 1'b1, 1'b0);
    tick();
    chk("post_rst_bin", {28'd0, bin}, 32'd4);
    chk("post_rst_dir", {30'd0, dir}, 32'd0);
    chk("post_rst_err", {31'd0, step_err}, 32'd0);
    chk("post_rst_state", {31'd0, state}, 32'd1);

    // Saturation: bin 0 / bin 8 alternating gives a jump on every word after the first.
    do_reset();
    drive(4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive((i % 2 == 0) ? 4'b1100 : 4'b0000, 1'b1, 1'b1, 1'b0);
      tick();
      chk($sformatf("sat%0d_dir", i), {30'd0, dir2}, 32'd3);
      chk($sformatf("sat%0d_cnt2", i), {30'd0, err_cnt2}, (i < 3) ? i + 1 : 3);
      chk($sformatf("sat%0d_cnt8", i), {24'd0, err_cnt}, i + 1);
    end

`ifdef GRAY_DEC_PARITY_EN
    // Bad parity: flagged, counted, reference stays at bin 0.
    do_reset();
    par_flip = 1'b1;
    drive(4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk("par_noref_state", {31'd0, state}, 32'd0);
    chk("par_noref_flag", {31'd0, par_err}, 32'd1);
    par_flip = 1'b0;
    drive(4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    par_flip = 1'b1;
    drive(4'b0001, 1'b1, 1'b1, 1'b0);
    tick();
    chk("par_flag", {31'd0, par_err}, 32'd1);
    chk("par_cnt", {24'd0, err_cnt}, 32'd2);
    par_flip = 1'b0;
    drive(4'b0001, 1'b1, 1'b1, 1'b0);
    tick();
    chk("par_ref_kept_dir", {30'd0, dir}, 32'd1);
    chk("par_clean_flag", {31'd0, par_err}, 32'd0);
    chk("par_clean_cnt", {24'd0, err_cnt}, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_stream_decoder.md
Name: gray_stream_decoder

Overview:
- Streaming Gray-to-binary decoder with valid/ready handshake on both sides; the receive-side counterpart of the team's binary-to-Gray encoder.
- Registers each decoded word and classifies the step from the previously accepted word as hold, up, down or jump.
- Keeps a saturating error count of illegal steps.
- Sits on the consumer side of Gray-coded counter and pointer streams.

Parameters:
- VEC_W, 4, width of Gray input and binary output (≥2).
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear_i  input  1  synchronous clear: forget the reference word and zero err_cnt_o.
- gray_i  input  VEC_W  Gray-coded input word.
- in_valid_i  input  1  gray_i valid.
- in_ready_o  output  1  decoder can accept.
- bin_o  output  VEC_W  decoded binary word.
- dir_o  output  2  step class: 00 hold, 01 up, 10 down, 11 jump.
- step_err_o  output  1  current output beat is an illegal step.
- out_valid_o  output  1  bin_o/dir_o/step_err_o valid.
- out_ready_i  input  1  downstream accepts.
- err_cnt_o  output  ERR_CNT_W  saturating count of illegal steps.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - out_valid_o=0, bin_o=0, dir_o=00, step_err_o=0, err_cnt_o=0.
  - State NOREF, prev_bin=0.
  - in_ready_o follows the combinational rule below, so it reads 1 during reset.
- Handshakes:
  - Input accepted when in_valid_i && in_ready_o.
  - Output transfers when out_valid_o && out_ready_i.
- in_ready_o = !out_valid_o || out_ready_i. Full throughput of one word per cycle; no combinational path from in_valid_i to out_valid_o.
- Latency: accepted word appears on bin_o with out_valid_o=1 on the next rising edge.
- Output stability: bin_o/dir_o/step_err_o hold stable while out_valid_o && !out_ready_i.
- Decode rule: bin[VEC_W-1]=gray[VEC_W-1]; bin[i]=bin[i+1]^gray[i] for i=VEC_W-2..0.
- Step classification: d = (bin_new - prev_bin) mod 2^VEC_W.
  - d==0: hold, 00.
  - d==1: up, 01.
  - d==2^VEC_W-1: down, 10.
  - Otherwise: jump, 11, with step_err_o=1.
- Wrap-around is legal:
  - Max→0 is up.
  - 0→max is down.
- State machine:
  - NOREF: first accepted word gives dir_o=00, step_err_o=0; prev_bin←bin_new; go to TRACK.
  - TRACK: classify each accepted word against prev_bin; prev_bin←bin_new on every accept.
  - clear_i=1 in either state: next state NOREF, err_cnt_o←0.
- err_cnt_o:
  - Increments on the edge that loads a beat with step_err_o=1.
  - Saturates at 2^ERR_CNT_W-1.
- clear_i and accept in the same cycle:
  - Accepted word is loaded to the output.
  - It is classified as a NOREF word: hold, no error, counter stays 0.
  - It becomes the new reference; state ends in TRACK.
- clear_i never drops a pending output beat; out_valid_o is unaffected.
- Simultaneous output transfer and input accept: new beat replaces the old one, out_valid_o stays 1.

Optional Feature:
- Macro GRAY_DEC_PARITY_EN.
- When defined, adds:
  - gray_par_i, input, 1: even parity over gray_i.
  - par_err_o, output, 1: registered with the beat.
- Behaviour with the macro:
  - Parity mismatch on an accepted word sets par_err_o=1 and increments err_cnt_o (once per beat, even if it is also a jump).
  - A parity-failed word does not update prev_bin.
  - A parity-failed word arriving in NOREF leaves the state in NOREF.
- When undefined: ports absent, parity logic absent, behaviour exactly as above.

Test Plan:
- Sequence (VEC_W=4), out_ready_i=1:
  - Reset, then gray 0000,0001,0011,0010 → bin 0,1,2,3.
  - dir 00,01,01,01, one cycle latency each, err_cnt_o=0.
- Wrap:
  - gray 1000 (bin 15) then 0000 → dir 01, no error.
  - Then 1000 → dir 10, no error.
- Jump:
  - bin 3 (0010) then gray 0100 (bin 7) → dir 11, step_err_o=1, err_cnt_o=1.
  - Next gray 1100 (bin 8) → dir 01, no error.
- Backpressure:
  - Hold out_ready_i=0 for 3 cycles with in_valid_i=1 → bin_o stable, in_ready_o=0.
  - Release → no word lost or duplicated.
- Clear/reset:
  - clear_i in the same cycle as accepting bin 9 → dir 00, err_cnt_o=0.
  - reset_n pulsed low mid-stream with out_valid_o=1 → out_valid_o=0 immediately, next word treated as NOREF.
- Saturation:
  - ERR_CNT_W=2, five consecutive jumps → err_cnt_o stops at 3.
  - With GRAY_DEC_PARITY_EN, a bad-parity word → par_err_o=1 and prev_bin unchanged.
